// File: rtl/apb_master_bridge_if.sv
// apb_master_bridge_if: command/response stream and APB3 bus signals of the bridge
interface apb_master_bridge_if #(
    parameter int ADR_W = 32,
    parameter int DAT_W = 32
) ();
    logic             cmd_valid_i;
    logic             cmd_ready_o;
    logic             cmd_we_i;
    logic [ADR_W-1:0] cmd_adr_i;
    logic [DAT_W-1:0] cmd_dat_i;
    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic [DAT_W-1:0] rsp_dat_o;
    logic             rsp_err_o;
    logic [ADR_W-1:0] p_adr_o;
    logic [DAT_W-1:0] p_dat_o;
    logic [DAT_W-1:0] p_dat_i;
    logic             p_sel_o;
    logic             p_enable_o;
    logic             p_we_o;
    logic             p_ready_i;

    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, rsp_ready_i, p_dat_i, p_ready_i,
        output cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
        output p_adr_o, p_dat_o, p_sel_o, p_enable_o, p_we_o
    );

    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, rsp_ready_i, p_dat_i, p_ready_i,
        input  cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
        input  p_adr_o, p_dat_o, p_sel_o, p_enable_o, p_we_o
    );
endinterface

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-outstanding APB3 master driven by a valid/ready command stream
module apb_master_bridge #(
    parameter int ADR_W   = 32,
    parameter int DAT_W   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                p_clk_i,
    input  logic                p_rst_i,
    apb_master_bridge_if.master bus,
    output logic [15:0]         txn_cnt_o
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [ADR_W-1:0] r_adr;
    logic [DAT_W-1:0] r_dat;
    logic             r_we;
    logic             r_sel;
    logic             r_enable;
    logic [7:0]       r_wait;
    logic [DAT_W-1:0] r_rsp_dat;
    logic             r_rsp_err;
    logic [15:0]      r_txn;
    logic             w_accept;
    logic             w_misaligned;
    logic             w_timeout;
    logic             w_finish;
    logic             w_busy;
    logic             w_done;

    // next-state decode and handshake qualifiers
    always_comb begin
        w_accept     = bus.cmd_valid_i && (r_state == IDLE);
        w_misaligned = bus.cmd_adr_i[1:0] != 2'b00;
        w_timeout    = !bus.p_ready_i && (r_wait == 8'(TIMEOUT - 1));
        w_next       = r_state;
        case (r_state)
            IDLE:    w_next = w_accept ? (w_misaligned ? RESP : SETUP) : IDLE;
            SETUP:   w_next = ACCESS;
            ACCESS:  w_next = (bus.p_ready_i || w_timeout) ? RESP : ACCESS;
            RESP:    w_next = bus.rsp_ready_i ? IDLE : RESP;
            default: w_next = IDLE;
        endcase
        w_finish = (r_state == ACCESS) && (w_next == RESP);
        w_busy   = (w_next == SETUP) || (w_next == ACCESS);
        w_done   = (r_state == RESP) && bus.rsp_ready_i;
    end

    // state, registered APB outputs, wait counter, response and transaction count
    always_ff @(posedge p_clk_i) begin
        if (!p_rst_i) begin
            r_state   <= IDLE;
            r_adr     <= '0;
            r_dat     <= '0;
            r_we      <= 1'b0;
            r_sel     <= 1'b0;
            r_enable  <= 1'b0;
            r_wait    <= 8'd0;
            r_rsp_dat <= '0;
            r_rsp_err <= 1'b0;
            r_txn     <= 16'd0;
        end else begin
            r_state   <= w_next;
            r_sel     <= w_busy;
            r_enable  <= w_next == ACCESS;
            r_adr     <= !w_busy ? '0 : w_accept ? bus.cmd_adr_i : r_adr;
            r_dat     <= !w_busy ? '0 : w_accept ? bus.cmd_dat_i : r_dat;
            r_we      <= !w_busy ? 1'b0 : w_accept ? bus.cmd_we_i : r_we;
            r_wait    <= (r_state == ACCESS && !bus.p_ready_i) ? r_wait + 8'd1 : 8'd0;
            r_rsp_dat <= (w_finish && bus.p_ready_i && !r_we) ? bus.p_dat_i :
                         (r_state == RESP) ? r_rsp_dat : '0;
            r_rsp_err <= (r_state == RESP) ? r_rsp_err :
                         (w_accept && w_misaligned) || (w_finish && !bus.p_ready_i);
            r_txn     <= r_txn + 16'(w_done);
        end
    end

    assign bus.cmd_ready_o = r_state == IDLE;
    assign bus.rsp_valid_o = r_state == RESP;
    assign bus.rsp_dat_o   = r_rsp_dat;
    assign bus.rsp_err_o   = r_rsp_err;
    assign bus.p_adr_o     = r_adr;
    assign bus.p_dat_o     = r_dat;
    assign bus.p_we_o      = r_we;
    assign bus.p_sel_o     = r_sel;
    assign bus.p_enable_o  = r_enable;
    assign txn_cnt_o       = r_txn;
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: directed commands with a response scoreboard and a programmable APB slave
module tb_apb_master_bridge;
    typedef struct {
        logic [31:0] dat;
        logic        err;
        int          lat;
        int          sel_n;
        int          en_n;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] txn_cnt;
    int          vecs;
    int          errs;
    int          cyc;
    int          done;
    int          slave_wait;
    bit          slave_never;
    logic [31:0] slave_rdata;
    exp_t        q[$];

    apb_master_bridge_if #(.ADR_W(32), .DAT_W(32)) bif ();

    apb_master_bridge #(.ADR_W(32), .DAT_W(32), .TIMEOUT(4)) dut (
        .p_clk_i   (clk),
        .p_rst_i   (rst_n),
        .bus       (bif),
        .txn_cnt_o (txn_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // APB slave: ready after slave_wait stalled ACCESS cycles, or never
    initial begin
        int acc_n;
        acc_n = 0;
        bif.p_ready_i = 1'b0;
        bif.p_dat_i = '0;
        forever begin
            @(negedge clk);
            if (bif.p_sel_o === 1'b1 && bif.p_enable_o === 1'b1) begin
                bif.p_ready_i = !slave_never && (acc_n == slave_wait);
                acc_n++;
            end else begin
                acc_n = 0;
                bif.p_ready_i = 1'b0;
            end
            bif.p_dat_i = slave_rdata;
        end
    end

    // monitor: measures latency and bus activity, pops the scoreboard on each consumed response
    initial begin
        int acc_cyc, sel_n, en_n, lat;
        bit held;
        logic [31:0] hdat;
        logic herr;
        exp_t e;
        acc_cyc = 0; sel_n = 0; en_n = 0; lat = 0; held = 0; hdat = '0; herr = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                held = 0;
            end else if (bif.rsp_valid_o === 1'b1) begin
                if (!held) lat = cyc - acc_cyc;
                else begin
                    chk("rsp_dat_stable", bif.rsp_dat_o, hdat);
                    chk("rsp_err_stable", {31'd0, bif.rsp_err_o}, {31'd0, herr});
                end
                if (bif.rsp_ready_i === 1'b1) begin
                    if (q.size() == 0) begin
                        vecs++; errs++;
                        $display("FAIL unexpected_rsp: got response expected none");
                    end else begin
                        e = q.pop_front();
                        chk("rsp_dat", bif.rsp_dat_o, e.dat);
                        chk("rsp_err", {31'd0, bif.rsp_err_o}, {31'd0, e.err});
                        chk("rsp_latency", lat, e.lat);
                        chk("psel_cycles", sel_n, e.sel_n);
                        chk("penable_cycles", en_n, e.en_n);
                    end
                    held = 0;
                    done++;
                end else begin
                    held = 1;
                    hdat = bif.rsp_dat_o;
                    herr = bif.rsp_err_o;
                end
            end else if (bif.cmd_valid_i === 1'b1 && bif.cmd_ready_o === 1'b1) begin
                acc_cyc = cyc; sel_n = 0; en_n = 0;
            end else if (bif.p_sel_o === 1'b1) begin
                sel_n++;
                if (bif.p_enable_o === 1'b1) en_n++;
            end
        end
    end

    task automatic send(input logic we, input logic [31:0] adr, input logic [31:0] dat, input bit push,
                        input logic [31:0] edat, input logic eerr, input int lat, input int seln, input int enn);
        int n;
        if (push) q.push_back('{edat, eerr, lat, seln, enn});
        @(posedge clk); #1;
        bif.cmd_valid_i = 1'b1;
        bif.cmd_we_i = we;
        bif.cmd_adr_i = adr;
        bif.cmd_dat_i = dat;
        n = 0;
        @(negedge clk);
        while (bif.cmd_ready_o !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            vecs++; errs++;
            $display("FAIL accept_timeout: got no cmd_ready expected accept");
        end
        @(posedge clk); #1;
        bif.cmd_valid_i = 1'b0;
        bif.cmd_we_i = ~we;
        bif.cmd_adr_i = 32'hFFFF_FFF0;
        bif.cmd_dat_i = ~dat;
        @(negedge clk);
        if (adr[1:0] != 2'b00) begin
            chk("misaligned_psel", {31'd0, bif.p_sel_o}, 32'd0);
        end else begin
            chk("setup_psel", {31'd0, bif.p_sel_o}, 32'd1);
            chk("setup_penable", {31'd0, bif.p_enable_o}, 32'd0);
            chk("setup_pwrite", {31'd0, bif.p_we_o}, {31'd0, we});
            chk("setup_paddr", bif.p_adr_o, adr);
            chk("setup_pwdata", bif.p_dat_o, dat);
        end
    endtask

    task automatic wait_done(input int target, input logic [15:0] etxn);
        int n;
        n = 0;
        while (done < target && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (done < target) begin
            vecs++; errs++;
            $display("FAIL rsp_timeout: got %0d responses expected %0d", done, target);
        end
        @(negedge clk);
        chk("txn_cnt", {16'd0, txn_cnt}, {16'd0, etxn});
    endtask

    initial begin
        vecs = 0; errs = 0; done = 0;
        slave_wait = 0; slave_never = 0; slave_rdata = '0;
        rst_n = 1'b0;
        bif.cmd_valid_i = 1'b0;
        bif.cmd_we_i = 1'b0;
        bif.cmd_adr_i = '0;
        bif.cmd_dat_i = '0;
        bif.rsp_ready_i = 1'b1;
        // reset held for two edges, bus must be idle
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_psel", {31'd0, bif.p_sel_o}, 32'd0);
        chk("rst_penable", {31'd0, bif.p_enable_o}, 32'd0);
        chk("rst_pwrite", {31'd0, bif.p_we_o}, 32'd0);
        chk("rst_paddr", bif.p_adr_o, 32'd0);
        chk("rst_pwdata", bif.p_dat_o, 32'd0);
        chk("rst_rsp_valid", {31'd0, bif.rsp_valid_o}, 32'd0);
        chk("rst_txn_cnt", {16'd0, txn_cnt}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_cmd_ready", {31'd0, bif.cmd_ready_o}, 32'd1);
        // zero-wait write to the CRC8 wrapper
        slave_wait = 0; slave_rdata = 32'h0000_0111;
        send(1'b1, 32'h0, 32'hAA, 1, 32'h0, 1'b0, 3, 2, 1);
        wait_done(1, 16'd1);
        // read with two wait states
        slave_wait = 2; slave_rdata = 32'h5C;
        send(1'b0, 32'h4, 32'h0, 1, 32'h5C, 1'b0, 5, 4, 3);
        wait_done(2, 16'd2);
        // write with one wait state, read data on the bus must not leak into the response
        slave_wait = 1; slave_rdata = 32'h999;
        send(1'b1, 32'h10, 32'h1234, 1, 32'h0, 1'b0, 4, 3, 2);
        wait_done(3, 16'd3);
        // zero-wait read of a full-width value
        slave_wait = 0; slave_rdata = 32'hDEAD_BEEF;
        send(1'b0, 32'hC, 32'h0, 1, 32'hDEAD_BEEF, 1'b0, 3, 2, 1);
        wait_done(4, 16'd4);
        // slave never ready: abort after four ACCESS cycles
        slave_never = 1; slave_rdata = 32'hBAD;
        send(1'b0, 32'h8, 32'h0, 1, 32'h0, 1'b1, 6, 5, 4);
        wait_done(5, 16'd5);
        slave_never = 0;
        // misaligned read with response backpressure
        @(posedge clk); #1;
        bif.rsp_ready_i = 1'b0;
        send(1'b0, 32'h6, 32'h0, 1, 32'h0, 1'b1, 1, 0, 0);
        repeat (3) begin
            @(negedge clk);
            chk("bp_cmd_ready", {31'd0, bif.cmd_ready_o}, 32'd0);
            chk("bp_rsp_valid", {31'd0, bif.rsp_valid_o}, 32'd1);
        end
        @(posedge clk); #1;
        bif.rsp_ready_i = 1'b1;
        wait_done(6, 16'd6);
        // misaligned write, consumed at once
        send(1'b1, 32'h13, 32'h55, 1, 32'h0, 1'b1, 1, 0, 0);
        wait_done(7, 16'd7);
        // reset in the middle of ACCESS aborts without a response
        slave_never = 1;
        send(1'b0, 32'h20, 32'h0, 0, 32'h0, 1'b0, 0, 0, 0);
        begin
            int n;
            n = 0;
            while (bif.p_enable_o !== 1'b1 && n < 10) begin
                @(negedge clk);
                n++;
            end
            chk("midrst_in_access", {31'd0, bif.p_enable_o}, 32'd1);
        end
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_psel", {31'd0, bif.p_sel_o}, 32'd0);
        chk("midrst_penable", {31'd0, bif.p_enable_o}, 32'd0);
        chk("midrst_rsp_valid", {31'd0, bif.rsp_valid_o}, 32'd0);
        chk("midrst_txn_cnt", {16'd0, txn_cnt}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        slave_never = 0;
        @(negedge clk);
        chk("midrst_cmd_ready", {31'd0, bif.cmd_ready_o}, 32'd1);
        // normal read after the aborted transfer
        slave_wait = 0; slave_rdata = 32'h77;
        send(1'b0, 32'h24, 32'h0, 1, 32'h77, 1'b0, 3, 2, 1);
        wait_done(8, 16'd1);
        chk("scoreboard_empty", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
